// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a combinational instruction memory,
// buffers {instr, pc} pairs in a small FIFO and issues them over valid/ready.
module fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc;
    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [31:0]      target_aligned;
    logic             pop;
    logic             push;

    assign imem_addr      = fetch_pc;
    assign target_aligned = branch_target & 32'hFFFF_FFFC;

    // Outputs come from registers only; no path from instr_ready or branch_valid.
    assign instr_valid = (count != '0);
    assign instr       = instr_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];

    always_comb begin
        pop  = instr_valid && instr_ready;
        push = !branch_valid && ((count < FULL_CNT) || pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (branch_valid) begin
            // A handshake completing now is already delivered; everything else is dropped.
            fetch_pc <= target_aligned;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= imem_rd;
                pc_mem[wr_ptr]    <= fetch_pc;
                wr_ptr            <= wr_ptr + 1'b1;
                fetch_pc          <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected {pc, instr} pairs are queued as stimulus
// is driven and compared against every completed decode handshake.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc)
    );

    always #5 clk = ~clk;

    // Memory holds word i = E000_0000 + i.
    assign imem_rd = 32'hE000_0000 + {2'b00, imem_addr[31:2]};

    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] pc;
        exp_t        e;
        pc = start;
        for (int i = 0; i < n; i++) begin
            e.pc  = pc;
            e.ins = 32'hE000_0000 + (pc >> 2);
            sb.push_back(e);
            pc = pc + 32'd4;
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && instr_valid && instr_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_issue got pc=%h instr=%h, expected no issue", instr_pc, instr);
                end else begin
                    e = sb.pop_front();
                    if (instr_pc !== e.pc || instr !== e.ins)
                        $display("FAIL scoreboard got pc=%h instr=%h, expected pc=%h instr=%h",
                                 instr_pc, instr, e.pc, e.ins);
                    else
                        n_pass++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        sb.delete();
        reset = 1'b1;
        branch_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Run until the scoreboard is empty, then drop instr_ready right after the last handshake.
    task automatic drain(input int bound, input bit gapless);
        for (int i = 0; i < bound; i++) begin
            if (gapless && sb.size() != 0) begin
                n_checks++;
                if (instr_valid !== 1'b1) $display("FAIL bubble got instr_valid=%b, expected 1", instr_valid);
                else n_pass++;
            end
            step();
            if (sb.size() == 0) begin
                instr_ready = 1'b0;
                return;
            end
        end
        n_checks++;
        $display("FAIL drain_timeout got %0d entries left, expected 0", sb.size());
        instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++; if (imem_addr !== 32'h0) $display("FAIL reset_addr got %h, expected 0", imem_addr); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b, expected 0", instr_valid); else n_pass++;
        n_checks++; if (instr !== 32'h0) $display("FAIL reset_instr got %h, expected 0", instr); else n_pass++;
        n_checks++; if (instr_pc !== 32'h0) $display("FAIL reset_pc got %h, expected 0", instr_pc); else n_pass++;
    endtask

    task automatic test_startup();
        instr_ready = 1'b1;
        apply_reset();
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL startup_R_valid got %b, expected 0", instr_valid); else n_pass++;
        push_seq(32'h0, 8);
        step();
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0)
            $display("FAIL startup_first got valid=%b pc=%h, expected valid=1 pc=0", instr_valid, instr_pc);
        else n_pass++;
        drain(40, 1'b1);
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 6; i++) step();
        n_checks++; if (imem_addr !== 32'h8) $display("FAIL bp_addr got %h, expected 8", imem_addr); else n_pass++;
        n_checks++; if (instr !== 32'hE000_0000) $display("FAIL bp_head got %h, expected E0000000", instr); else n_pass++;
        n_checks++; if (instr_valid !== 1'b1) $display("FAIL bp_valid got %b, expected 1", instr_valid); else n_pass++;
        push_seq(32'h0, 6);
        instr_ready = 1'b1;
        drain(40, 1'b1);
    endtask

    task automatic test_branch_full();
        instr_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 3; i++) step();
        branch_valid  = 1'b1;
        branch_target = 32'h0000_0043;
        step();
        branch_valid = 1'b0;
        n_checks++; if (imem_addr !== 32'h40) $display("FAIL brfull_addr got %h, expected 40", imem_addr); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL brfull_bubble got %b, expected 0", instr_valid); else n_pass++;
        push_seq(32'h40, 4);
        instr_ready = 1'b1;
        step();
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40)
            $display("FAIL brfull_target got valid=%b pc=%h, expected valid=1 pc=40", instr_valid, instr_pc);
        else n_pass++;
        drain(40, 1'b1);
    endtask

    task automatic test_branch_handshake();
        instr_ready = 1'b1;
        apply_reset();
        push_seq(32'h0, 2);
        step();
        step();
        n_checks++; if (instr_pc !== 32'h4) $display("FAIL brhs_head got %h, expected 4", instr_pc); else n_pass++;
        branch_valid  = 1'b1;
        branch_target = 32'h0000_0100;
        step();
        branch_valid = 1'b0;
        n_checks++; if (sb.size() != 0) $display("FAIL brhs_delivered got %0d pending, expected 0", sb.size()); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL brhs_bubble got %b, expected 0", instr_valid); else n_pass++;
        push_seq(32'h100, 3);
        step();
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100)
            $display("FAIL brhs_target got valid=%b pc=%h, expected valid=1 pc=100", instr_valid, instr_pc);
        else n_pass++;
        drain(40, 1'b1);
    endtask

    task automatic test_wrap();
        instr_ready = 1'b0;
        apply_reset();
        step();
        branch_valid  = 1'b1;
        branch_target = 32'hFFFF_FFF8;
        step();
        branch_valid = 1'b0;
        push_seq(32'hFFFF_FFF8, 3);
        instr_ready = 1'b1;
        step();
        n_checks++; if (instr_pc !== 32'hFFFF_FFF8) $display("FAIL wrap_first got %h, expected FFFFFFF8", instr_pc); else n_pass++;
        drain(40, 1'b1);
    endtask

    task automatic test_reset_mid();
        instr_ready = 1'b1;
        apply_reset();
        push_seq(32'h0, 20);
        for (int i = 0; i < 4; i++) step();
        sb.delete();
        reset         = 1'b1;
        branch_valid  = 1'b1;
        branch_target = 32'h0000_0200;
        step();
        reset        = 1'b0;
        branch_valid = 1'b0;
        n_checks++; if (imem_addr !== 32'h0) $display("FAIL rstmid_addr got %h, expected 0", imem_addr); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL rstmid_valid got %b, expected 0", instr_valid); else n_pass++;
        push_seq(32'h0, 3);
        step();
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0)
            $display("FAIL rstmid_first got valid=%b pc=%h, expected valid=1 pc=0", instr_valid, instr_pc);
        else n_pass++;
        drain(40, 1'b1);
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_startup();
        test_backpressure();
        test_branch_full();
        test_branch_handshake();
        test_wrap();
        test_reset_mid();
        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
